dl_sequencer: RTL and testbench

DL_SEQUENCER -- requirements
Module: dl_sequencer

---
 rtl/dl_sequencer.sv | 156 +++++++++++++++
 tb/tb_dl_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_sequencer.sv
// dl_sequencer: on a RUN command, launches 2^k delay-line shots, accumulates the
// popcount of each captured tap snapshot, then returns the 14-bit sum as two bytes.
module dl_sequencer #(
    parameter int CAPTURE_LAT = 3,
    parameter int MAX_LOG2    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_valid,
    input  logic        i_accept,
    output logic [7:0]  o_data,
    output logic        o_start,
    input  logic [31:0] i_dl,
    output logic        o_busy
);

    localparam int         CNT_W     = MAX_LOG2 + 1;
    localparam logic [3:0] OP_RUN    = 4'h3;
    localparam logic [3:0] OP_ABORT  = 4'h4;
    localparam logic [3:0] K_MAX     = 4'(MAX_LOG2);
    // Last WAIT count value; only meaningful when CAPTURE_LAT >= 2.
    localparam logic [3:0] WAIT_LAST = 4'(CAPTURE_LAT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT,
        S_CAPT,
        S_TX_HI,
        S_TX_LO
    } state_t;

    state_t             state_q;
    logic [3:0]         k_q;
    logic [13:0]        acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         wait_q;
    logic               o_valid_q;
    logic               o_start_q;
    logic               o_busy_q;
    logic [7:0]         o_data_q;

    logic [5:0]         pop_d;
    logic [13:0]        acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   target_d;
    logic [3:0]         k_d;
    logic               run_cmd;
    logic               abort_cmd;

    assign run_cmd   = i_valid && (i_data[3:0] == OP_RUN);
    assign abort_cmd = i_valid && (i_data[3:0] == OP_ABORT);
    assign k_d       = (i_data[7:4] > K_MAX) ? K_MAX : i_data[7:4];
    assign acc_d     = acc_q + {8'd0, pop_d};
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign target_d  = {{(CNT_W-1){1'b0}}, 1'b1} << k_q;

    // Number of set taps in the current delay-line snapshot (0..32).
    always_comb begin
        pop_d = '0;
        for (int i = 0; i < 32; i++) begin
            pop_d = pop_d + {5'd0, i_dl[i]};
        end
    end

    // Sequencer FSM; all outputs are registered and set alongside the state they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            o_valid_q <= 1'b0;
            o_start_q <= 1'b0;
            o_busy_q  <= 1'b0;
            o_data_q  <= 8'h00;
        end else if (abort_cmd) begin
            // ABORT overrides everything, including a byte accept in the same cycle.
            state_q   <= S_IDLE;
            o_valid_q <= 1'b0;
            o_start_q <= 1'b0;
            o_busy_q  <= 1'b0;
            o_data_q  <= 8'h00;
        end else begin
            o_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run_cmd) begin
                        k_q       <= k_d;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_FIRE;
                        o_start_q <= 1'b1;
                        o_busy_q  <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (CAPTURE_LAT == 1) begin
                        state_q <= S_CAPT;
                    end else begin
                        wait_q  <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= S_CAPT;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                S_CAPT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d < target_d) begin
                        state_q   <= S_FIRE;
                        o_start_q <= 1'b1;
                    end else begin
                        state_q   <= S_TX_HI;
                        o_valid_q <= 1'b1;
                        o_data_q  <= {2'b00, acc_d[13:8]};
                    end
                end
                S_TX_HI: begin
                    if (i_accept) begin
                        state_q  <= S_TX_LO;
                        o_data_q <= acc_q[7:0];
                    end
                end
                S_TX_LO: begin
                    if (i_accept) begin
                        state_q   <= S_IDLE;
                        o_valid_q <= 1'b0;
                        o_busy_q  <= 1'b0;
                        o_data_q  <= 8'h00;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    o_valid_q <= 1'b0;
                    o_busy_q  <= 1'b0;
                    o_data_q  <= 8'h00;
                end
            endcase
        end
    end

    assign o_valid = o_valid_q;
    assign o_start = o_start_q;
    assign o_busy  = o_busy_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_dl_sequencer.sv
// Scoreboard bench for dl_sequencer: the reference model predicts launch times and
// result bytes from the command timing and the per-cycle tap snapshots.
module tb_dl_sequencer;

    localparam int L    = 3;
    localparam int MAXC = 30000;
    localparam logic [3:0] RUN   = 4'h3;
    localparam logic [3:0] ABORT = 4'h4;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_valid;
    logic        i_accept;
    logic [7:0]  o_data;
    logic        o_start;
    logic [31:0] i_dl;
    logic        o_busy;

    dl_sequencer #(.CAPTURE_LAT(L), .MAX_LOG2(8)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_accept (i_accept),
        .o_data   (o_data),
        .o_start  (o_start),
        .i_dl     (i_dl),
        .o_busy   (o_busy)
    );

    typedef struct {
        logic [7:0] val;
        bit         last;
        int         rise;
    } byte_exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          acc_mode = 1;   // 0 random, 1 always accept, 2 never accept
    bit          mdl_busy = 0;
    int          starts_seen = 0;
    int          bytes_rx = 0;
    logic [7:0]  rx_prev = 8'h00;
    logic [7:0]  rx_last = 8'h00;
    bit          prev_valid = 0;
    bit          prev_acc = 0;
    logic [7:0]  prev_data = 8'h00;
    logic [31:0] dl_hist [0:MAXC-1];
    int          exp_start_q [$];
    byte_exp_t   exp_byte_q [$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] dl_at(input int c);
        return dl_hist[c % MAXC];
    endfunction

    function automatic int popc(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Background driver: tap snapshot and accept policy change just after each rising edge.
    always @(posedge i_clk) begin
        #1;
        i_dl = dl_at(cyc);
        case (acc_mode)
            0:       i_accept = 1'($urandom_range(0, 1));
            1:       i_accept = 1'b1;
            default: i_accept = 1'b0;
        endcase
    end

    // Reference model: a RUN accepted in cycle c launches at c+1 and every L+1 cycles after,
    // each shot's snapshot is the one present L cycles after its launch.
    task automatic model_run(input int c, input logic [3:0] arg);
        int kk, n, s, sum;
        byte_exp_t b;
        kk  = (arg > 4'd8) ? 8 : int'(arg);
        n   = 1 << kk;
        sum = 0;
        for (int j = 0; j < n; j++) begin
            s = c + 1 + j * (L + 1);
            exp_start_q.push_back(s);
            sum += popc(dl_at(s + L));
        end
        b.val  = 8'((sum >> 8) & 63);
        b.last = 0;
        b.rise = c + 1 + (n - 1) * (L + 1) + L + 1;
        exp_byte_q.push_back(b);
        b.val  = 8'(sum & 255);
        b.last = 1;
        b.rise = -1;
        exp_byte_q.push_back(b);
    endtask

    // Monitor: compares every observed launch, byte and busy level against the model.
    always @(negedge i_clk) begin
        bit busy_clear;
        byte_exp_t e;
        int es;
        busy_clear = 0;
        if (i_rst) begin
            chk({o_valid, o_start, o_busy, o_data} == 11'd0, "reset_outputs",
                {o_valid, o_start, o_busy, o_data}, 0);
            exp_start_q.delete();
            exp_byte_q.delete();
            mdl_busy   = 0;
            prev_valid = 0;
            prev_acc   = 0;
        end else begin
            chk(o_busy == mdl_busy, "busy", o_busy, mdl_busy);
            if (o_start) begin
                starts_seen++;
                if (exp_start_q.size() == 0) begin
                    chk(0, "spurious_start", cyc, -1);
                end else begin
                    es = exp_start_q.pop_front();
                    chk(cyc == es, "start_cycle", cyc, es);
                end
            end
            if (o_valid) begin
                if (exp_byte_q.size() == 0) begin
                    chk(0, "spurious_valid", o_data, -1);
                end else begin
                    if (!prev_valid && exp_byte_q[0].rise >= 0)
                        chk(cyc == exp_byte_q[0].rise, "valid_rise", cyc, exp_byte_q[0].rise);
                    if (prev_valid && !prev_acc)
                        chk(o_data == prev_data, "data_stable", o_data, prev_data);
                    if (i_accept) begin
                        e = exp_byte_q.pop_front();
                        chk(o_data == e.val, "tx_byte", o_data, e.val);
                        $display("byte %0d: 0x%02h at cycle %0d", bytes_rx, o_data, cyc);
                        bytes_rx++;
                        rx_prev = rx_last;
                        rx_last = o_data;
                        busy_clear = e.last;
                    end
                end
            end
            prev_valid = o_valid;
            prev_acc   = i_accept;
            prev_data  = o_data;
            if (i_valid && i_data[3:0] == ABORT) begin
                exp_start_q.delete();
                exp_byte_q.delete();
                mdl_busy = 0;
            end else if (i_valid && i_data[3:0] == RUN && !mdl_busy) begin
                mdl_busy = 1;
            end else if (busy_clear) begin
                mdl_busy = 0;
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic issue_cmd(input logic [3:0] op, input logic [3:0] arg);
        i_valid = 1'b1;
        i_data  = {arg, op};
        $display("cmd op=%0h arg=%0d at cycle %0d (busy=%0d)", op, arg, cyc, mdl_busy);
        if (op == RUN && !mdl_busy && !i_rst) model_run(cyc, arg);
        step();
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic fill_dl(input int from, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) dl_hist[(from + i) % MAXC] = v;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((mdl_busy || exp_start_q.size() != 0 || exp_byte_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            chk(0, "timeout", n, budget);
            exp_start_q.delete();
            exp_byte_q.delete();
        end
        step();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!o_valid && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk(0, "wait_valid_timeout", n, budget);
    endtask

    initial begin
        int base, rxb, n, k, op;
        for (int i = 0; i < MAXC; i++) begin
            n = $urandom_range(0, 32);
            dl_hist[i] = 32'((64'h1 << n) - 64'h1);
        end
        i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_accept = 1'b0; i_dl = dl_at(0);
        repeat (3) @(posedge i_clk);
        #2;
        i_rst = 1'b0;

        // k=0, half-full snapshot, accept tied high; RUN on the first edge after reset.
        acc_mode = 1;
        fill_dl(cyc + 1, 20, 32'h0000_FFFF);
        base = starts_seen; rxb = bytes_rx;
        issue_cmd(RUN, 4'd0);
        wait_done(200);
        chk(starts_seen - base == 1, "k0_starts", starts_seen - base, 1);
        chk(bytes_rx - rxb == 2, "k0_nbytes", bytes_rx - rxb, 2);
        chk(rx_prev == 8'h00, "k0_hi", rx_prev, 8'h00);
        chk(rx_last == 8'h10, "k0_lo", rx_last, 8'h10);
        chk(o_busy == 1'b0, "k0_idle", o_busy, 0);

        // k=4, full snapshot.
        fill_dl(cyc + 1, 120, 32'hFFFF_FFFF);
        base = starts_seen;
        issue_cmd(RUN, 4'd4);
        wait_done(300);
        chk(starts_seen - base == 16, "k4_starts", starts_seen - base, 16);
        chk(rx_prev == 8'h02, "k4_hi", rx_prev, 8'h02);
        chk(rx_last == 8'h00, "k4_lo", rx_last, 8'h00);

        // k=15 clamps to 256 shots.
        fill_dl(cyc + 1, 1100, 32'hFFFF_FFFF);
        base = starts_seen;
        issue_cmd(RUN, 4'd15);
        wait_done(2000);
        chk(starts_seen - base == 256, "k15_starts", starts_seen - base, 256);
        chk(rx_prev == 8'h20, "k15_hi", rx_prev, 8'h20);
        chk(rx_last == 8'h00, "k15_lo", rx_last, 8'h00);

        // k=2 with accept withheld; a RUN during the hold must be ignored.
        acc_mode = 2;
        base = starts_seen;
        issue_cmd(RUN, 4'd2);
        wait_valid(100);
        repeat (5) step();
        issue_cmd(RUN, 4'd1);
        repeat (4) step();
        chk(o_valid == 1'b1, "hold_valid", o_valid, 1);
        chk(o_data == 8'h00, "hold_data", o_data, 8'h00);
        acc_mode = 1;
        wait_done(100);
        chk(starts_seen - base == 4, "k2_starts", starts_seen - base, 4);
        chk(rx_prev == 8'h00, "k2_hi", rx_prev, 8'h00);

        // ABORT after the third launch of a k=3 run.
        base = starts_seen; rxb = bytes_rx;
        issue_cmd(RUN, 4'd3);
        n = 0;
        while (starts_seen < base + 3 && n < 100) begin step(); n++; end
        chk(starts_seen >= base + 3, "abort_reach3", starts_seen - base, 3);
        issue_cmd(ABORT, 4'd0);
        chk(o_busy == 1'b0, "abort_busy", o_busy, 0);
        repeat (40) step();
        chk(starts_seen - base == 3, "abort_starts", starts_seen - base, 3);
        chk(bytes_rx == rxb, "abort_nbytes", bytes_rx - rxb, 0);

        // ABORT coincident with accept of the high byte: low byte never appears.
        acc_mode = 2;
        rxb = bytes_rx;
        issue_cmd(RUN, 4'd0);
        wait_valid(100);
        acc_mode = 1;
        step();
        issue_cmd(ABORT, 4'd0);
        chk(o_valid == 1'b0, "abort_acc_valid", o_valid, 0);
        repeat (10) step();
        chk(bytes_rx - rxb == 1, "abort_acc_nbytes", bytes_rx - rxb, 1);

        // Reset during TX_HI, then a clean k=0 run with an empty snapshot.
        acc_mode = 2;
        issue_cmd(RUN, 4'd1);
        wait_valid(100);
        i_rst = 1'b1;
        #1;
        chk(o_valid == 1'b0, "rst_async_valid", o_valid, 0);
        chk(o_busy == 1'b0, "rst_async_busy", o_busy, 0);
        step();
        fill_dl(cyc + 1, 20, 32'h0);
        acc_mode = 1;
        rxb = bytes_rx;
        i_rst = 1'b0;
        issue_cmd(RUN, 4'd0);
        wait_done(100);
        chk(bytes_rx - rxb == 2, "rst_nbytes", bytes_rx - rxb, 2);
        chk(rx_prev == 8'h00, "rst_hi", rx_prev, 8'h00);
        chk(rx_last == 8'h00, "rst_lo", rx_last, 8'h00);

        // Randomized runs with noise commands, random accept and occasional aborts.
        for (int r = 0; r < 30; r++) begin
            acc_mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
            k = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 5);
            issue_cmd(RUN, 4'(k));
            repeat ($urandom_range(0, 4)) begin
                repeat ($urandom_range(0, 8)) step();
                op = $urandom_range(0, 15);
                if (op == 4) op = 5;
                issue_cmd(4'(op), 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 30)) step();
                issue_cmd(ABORT, 4'd0);
            end
            wait_done(3000);
        end

        chk(exp_start_q.size() == 0, "starts_drained", exp_start_q.size(), 0);
        chk(exp_byte_q.size() == 0, "bytes_drained", exp_byte_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
